// File: rtl/stream_demux_pkg.sv
// ---------------------------------------------------------------------------
// stream_demux_pkg
//   Shared types and constants for the stream_demux block.
//   lane_state_t : occupancy state of one output lane buffer
//   DROP_CNT_W   : width of the dropped-word counter
//   sat_inc()    : saturating increment used by the drop counter
// ---------------------------------------------------------------------------
package stream_demux_pkg;

    typedef enum logic {
        LANE_EMPTY = 1'b0,
        LANE_FULL  = 1'b1
    } lane_state_t;

    localparam int DROP_CNT_W = 8;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (v == '1) ? v : v + DROP_CNT_W'(1);
    endfunction

endpackage

// File: rtl/demux_slot.sv
// ---------------------------------------------------------------------------
// demux_slot
//   One-entry valid/ready buffer for a single output lane.
//   Ports:
//     clk, rst    clock, synchronous active-high reset
//     load        write data_in this cycle (only asserted when slot_ready=1)
//     data_in     word to store
//     out_ready   downstream consumer ready
//     slot_ready  slot can take a word this cycle (empty, or draining now)
//     out_valid   slot holds a word
//     out_data    stored word; stable while full and not drained
// ---------------------------------------------------------------------------
module demux_slot
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             out_ready,
    output logic             slot_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    lane_state_t      state_q, state_d;
    logic [WIDTH-1:0] data_q,  data_d;

    // A full slot that drains this cycle can be refilled in the same cycle,
    // which is what gives one word per cycle with no bubble.
    assign slot_ready = (state_q == LANE_EMPTY) || out_ready;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (load) begin
            // Load wins over drain: drain+load leaves the slot full with the new word.
            state_d = LANE_FULL;
            data_d  = data_in;
        end else if ((state_q == LANE_FULL) && out_ready) begin
            state_d = LANE_EMPTY;
        end
    end

    // NOTE: non-blocking assignments here so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LANE_EMPTY;
            // NOTE: the data register is reset too, so out_data reads 0 after reset.
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = (state_q == LANE_FULL);
    assign out_data  = data_q;

endmodule

// File: rtl/stream_demux.sv
// ---------------------------------------------------------------------------
// stream_demux
//   1-to-N_OUT registered demultiplexer with valid/ready handshakes.
//   A word on the input is steered to lane in_sel, where a one-entry buffer
//   holds it until that lane's consumer takes it. Selects that name no lane
//   (possible only when N_OUT is not a power of two) are accepted and dropped.
//   Ports:
//     clk, rst              clock, synchronous active-high reset
//     in_valid/in_ready     input handshake (in_ready forced 0 during reset)
//     in_data, in_sel       input word and destination lane
//     out_valid[i]          lane i holds a word
//     out_ready[i]          lane i consumer ready
//     out_data              lane i at [i*WIDTH +: WIDTH]
//     drop_err              one-cycle pulse after a dropped word
//     drop_cnt              saturating count of dropped words
// ---------------------------------------------------------------------------
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int N_OUT = 4,
    localparam int SEL_W = $clog2(N_OUT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [SEL_W-1:0]       in_sel,
    output logic [N_OUT-1:0]       out_valid,
    input  logic [N_OUT-1:0]       out_ready,
    output logic [N_OUT*WIDTH-1:0] out_data,
    output logic                   drop_err,
    output logic [DROP_CNT_W-1:0]  drop_cnt
);

    logic [N_OUT-1:0]      slot_ready;
    logic [N_OUT-1:0]      load;
    logic                  sel_hit;
    logic                  sel_ready;
    logic                  fire;
    logic                  drop_err_q, drop_err_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    // Decode in_sel against the real lanes. A select that matches no lane
    // leaves sel_ready at 1, so out-of-range words are always sunk.
    // in_ready depends only on in_sel, out_ready and lane state -- never on in_valid.
    always_comb begin
        sel_hit   = 1'b0;
        sel_ready = 1'b1;
        for (int i = 0; i < N_OUT; i++) begin
            if (in_sel == SEL_W'(i)) begin
                sel_hit   = 1'b1;
                sel_ready = slot_ready[i];
            end
        end
    end

    assign in_ready = !rst && sel_ready;
    assign fire     = in_valid && in_ready;

    // Gating by fire (and so by in_valid) keeps a don't-care in_sel/in_data
    // from reaching any lane while the input is idle.
    always_comb begin
        load = '0;
        for (int i = 0; i < N_OUT; i++) begin
            load[i] = fire && (in_sel == SEL_W'(i));
        end
    end

    for (genvar g = 0; g < N_OUT; g++) begin : g_slot
        demux_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk        (clk),
            .rst        (rst),
            .load       (load[g]),
            .data_in    (in_data),
            .out_ready  (out_ready[g]),
            .slot_ready (slot_ready[g]),
            .out_valid  (out_valid[g]),
            .out_data   (out_data[g*WIDTH +: WIDTH])
        );
    end

    always_comb begin
        drop_err_d = fire && !sel_hit;
        drop_cnt_d = drop_err_d ? sat_inc(drop_cnt_q) : drop_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_err_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            drop_err_q <= drop_err_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_err = drop_err_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_stream_demux.sv
// ---------------------------------------------------------------------------
// tb_stream_demux
//   Two instances: a 4-lane demux (power-of-two select) and a 3-lane demux
//   (select value 3 is out of range). Directed scenarios are followed by a
//   randomized run; every cycle is compared against a lane-occupancy model.
// ---------------------------------------------------------------------------
module tb_stream_demux;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 4-lane instance
    logic        in_valid4, in_ready4;
    logic [7:0]  in_data4;
    logic [1:0]  in_sel4;
    logic [3:0]  out_valid4, out_ready4;
    logic [31:0] out_data4;
    logic        drop_err4;
    logic [7:0]  drop_cnt4;

    // 3-lane instance
    logic        in_valid3, in_ready3;
    logic [7:0]  in_data3;
    logic [1:0]  in_sel3;
    logic [2:0]  out_valid3, out_ready3;
    logic [23:0] out_data3;
    logic        drop_err3;
    logic [7:0]  drop_cnt3;

    stream_demux #(.WIDTH(8), .N_OUT(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4), .in_sel(in_sel4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
        .drop_err(drop_err4), .drop_cnt(drop_cnt4)
    );

    stream_demux #(.WIDTH(8), .N_OUT(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3), .in_sel(in_sel3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
        .drop_err(drop_err3), .drop_cnt(drop_cnt3)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model (k=0: 4 lanes, k=1: 3 lanes) ----------
    bit         m_full [2][4];
    logic [7:0] m_data [2][4];
    int         m_cnt  [2];
    bit         m_err  [2];
    bit         stall  [2];

    function automatic int n_lanes(input int k);
        return (k == 0) ? 4 : 3;
    endfunction

    // A lane can take a word if it is empty or its consumer takes the old one now.
    function automatic bit exp_ready(input int k, input int sel, input logic [3:0] ordy);
        if (sel >= n_lanes(k)) return 1'b1;
        return !m_full[k][sel] || ordy[sel];
    endfunction

    task automatic model_step(input int k, input bit r, input bit v, input int sel,
                              input logic [7:0] d, input logic [3:0] ordy);
        bit fire;
        if (r) begin
            for (int i = 0; i < 4; i++) begin
                m_full[k][i] = 1'b0;
                m_data[k][i] = 8'h00;
            end
            m_cnt[k] = 0;
            m_err[k] = 1'b0;
            return;
        end
        fire     = v && exp_ready(k, sel, ordy);
        m_err[k] = fire && (sel >= n_lanes(k));
        if (m_err[k] && m_cnt[k] < 255) m_cnt[k]++;
        for (int i = 0; i < n_lanes(k); i++) begin
            if (m_full[k][i] && ordy[i]) m_full[k][i] = 1'b0;
            if (fire && sel == i) begin
                m_full[k][i] = 1'b1;
                m_data[k][i] = d;
            end
        end
    endtask

    task automatic check_outputs(input int k);
        logic [3:0]  ov;
        logic [31:0] od;
        logic        de;
        logic [7:0]  dc;
        logic [3:0]  exp_v;
        if (k == 0) begin
            ov = out_valid4; od = out_data4; de = drop_err4; dc = drop_cnt4;
        end else begin
            ov = {1'b0, out_valid3}; od = {8'h00, out_data3}; de = drop_err3; dc = drop_cnt3;
        end
        exp_v = '0;
        for (int i = 0; i < n_lanes(k); i++) exp_v[i] = m_full[k][i];
        check($sformatf("out_valid%0d", n_lanes(k)), ov, exp_v);
        for (int i = 0; i < n_lanes(k); i++)
            if (m_full[k][i])
                check($sformatf("lane_data%0d[%0d]", n_lanes(k), i), od[i*8 +: 8], m_data[k][i]);
        check($sformatf("drop_err%0d", n_lanes(k)), de, m_err[k]);
        check($sformatf("drop_cnt%0d", n_lanes(k)), dc, m_cnt[k]);
    endtask

    // One clock: inputs were driven at the negedge; check in_ready, clock,
    // advance the model, check registered outputs, return at the next negedge.
    task automatic tick();
        bit r4, r3;
        #1;
        r4 = rst ? 1'b0 : exp_ready(0, in_sel4, out_ready4);
        r3 = rst ? 1'b0 : exp_ready(1, in_sel3, {1'b0, out_ready3});
        check("in_ready4", in_ready4, r4);
        check("in_ready3", in_ready3, r3);
        stall[0] = in_valid4 && !r4 && !rst;
        stall[1] = in_valid3 && !r3 && !rst;
        @(posedge clk);
        model_step(0, rst, in_valid4, in_sel4, in_data4, out_ready4);
        model_step(1, rst, in_valid3, in_sel3, in_data3, {1'b0, out_ready3});
        #1;
        check_outputs(0);
        check_outputs(1);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        in_valid4 = 1'b0; in_sel4 = 2'd0; in_data4 = 8'h00; out_ready4 = 4'h0;
        in_valid3 = 1'b0; in_sel3 = 2'd0; in_data3 = 8'h00; out_ready3 = 3'h0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);

        // T1: reset with in_valid high for two cycles
        in_valid4 = 1'b1; in_sel4 = 2'd2; in_data4 = 8'h11; out_ready4 = 4'hF;
        in_valid3 = 1'b1; in_sel3 = 2'd3; in_data3 = 8'h22;
        repeat (2) tick();
        check("t1_out_valid", out_valid4, 4'b0000);
        check("t1_out_data", out_data4, 32'h0);
        check("t1_drop_cnt", drop_cnt3, 8'd0);
        rst = 1'b0;
        idle_inputs();

        // T2: steer A5 to lane 2, then hold it through 5 stalled cycles
        in_valid4 = 1'b1; in_sel4 = 2'd2; in_data4 = 8'hA5;
        tick();
        idle_inputs();
        check("t2_out_valid", out_valid4, 4'b0100);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_hold_lane2", out_data4[23:16], 8'hA5);
        end
        out_ready4 = 4'hF;
        tick();
        check("t2_drained", out_valid4, 4'b0000);
        idle_inputs();

        // T3: backpressure on lane 1, then drain+load in the same cycle
        in_valid4 = 1'b1; in_sel4 = 2'd1; in_data4 = 8'h3C;
        tick();
        in_data4 = 8'hC3;
        tick();
        check("t3_stalled_keeps_old", out_data4[15:8], 8'h3C);
        out_ready4 = 4'b0010;
        #1 check("t3_in_ready_on_drain", in_ready4, 1'b1);
        tick();
        check("t3_no_bubble_valid", out_valid4[1], 1'b1);
        check("t3_new_word", out_data4[15:8], 8'hC3);
        idle_inputs();
        out_ready4 = 4'hF;
        tick();

        // T4: stream 0..9 into lane 3 with its consumer always ready
        for (int i = 0; i < 10; i++) begin
            in_valid4 = 1'b1; in_sel4 = 2'd3; in_data4 = 8'(i); out_ready4 = 4'b1000;
            tick();
            check("t4_stream_valid", out_valid4[3], 1'b1);
            check("t4_stream_data", out_data4[31:24], 32'(i));
        end
        idle_inputs();
        out_ready4 = 4'hF;
        tick();
        check("t4_no_drops", drop_cnt4, 8'd0);
        idle_inputs();

        // T5: out-of-range select on the 3-lane instance
        in_valid3 = 1'b1; in_sel3 = 2'd3; in_data3 = 8'h77;
        tick();
        check("t5_drop_err", drop_err3, 1'b1);
        check("t5_drop_cnt", drop_cnt3, 8'd1);
        check("t5_lanes_untouched", out_valid3, 3'b000);
        idle_inputs();
        tick();
        check("t5_drop_err_pulse", drop_err3, 1'b0);
        in_valid3 = 1'b1; in_sel3 = 2'd3;
        for (int i = 0; i < 300; i++) begin
            in_data3 = 8'($urandom);
            tick();
        end
        check("t5_drop_cnt_sat", drop_cnt3, 8'd255);
        idle_inputs();

        // T6: reset while lanes 0 and 2 are full
        in_valid4 = 1'b1; in_sel4 = 2'd0; in_data4 = 8'h10;
        tick();
        in_sel4 = 2'd2; in_data4 = 8'h20;
        tick();
        check("t6_pre_reset", out_valid4, 4'b0101);
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_after_reset", out_valid4, 4'b0000);
        check("t6_cnt_cleared", drop_cnt3, 8'd0);
        in_valid4 = 1'b1; in_sel4 = 2'd0; in_data4 = 8'h5A;
        tick();
        check("t6_reload", out_valid4, 4'b0001);
        check("t6_reload_data", out_data4[7:0], 8'h5A);
        idle_inputs();

        // Randomized traffic on both instances; selects and data are held
        // while a word is stalled, as a producer must.
        for (int c = 0; c < 2000; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            if (!stall[0]) begin
                in_valid4 = 1'($urandom);
                in_sel4   = 2'($urandom);
                in_data4  = 8'($urandom);
            end
            if (!stall[1]) begin
                in_valid3 = 1'($urandom);
                in_sel3   = 2'($urandom);
                in_data3  = 8'($urandom);
            end
            out_ready4 = 4'($urandom) & 4'($urandom);
            out_ready3 = 3'($urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
